clk_gate_sequencer: RTL and testbench
=====================================

CLK_GATE_SEQUENCER -- requirements
Module: clk_gate_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4: number of gated clock domains (1..16).
REQ-002 SHALL have parameter WAKE_CYCLES, default 4: clock-settle cycles after enabling a domain (>=1).
REQ-003 SHALL have parameter IDLE_CYCLES, default 16: consecutive idle cycles before auto-gating (>=1).
REQ-004 SHALL have port clk_i, input, 1: single clock; all state is clocked on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port test_en_i, input, 1: scan/test mode override.
REQ-007 SHALL have port sw_en_i, input, NUM_DOMAINS: software keep-on request per domain (level).
REQ-008 SHALL have port wake_req_i, input, NUM_DOMAINS: external wake request per domain (level).
REQ-009 SHALL have port busy_i, input, NUM_DOMAINS: domain activity; meaningful only while the domain is ON.
REQ-010 SHALL have port clk_en_o, output, NUM_DOMAINS: enable to the domain's clock-gating cell en_i.
REQ-011 SHALL have port ready_o, output, NUM_DOMAINS: domain clock enabled and settled.
REQ-012 SHALL have port waking_o, output, 1: some domain is in WAKE.

Function
REQ-013 SHALL keep one FSM per domain with states OFF, REQ, WAKE, ON; demand[i] = sw_en_i[i] | wake_req_i[i].
REQ-014 SHALL decode OFF: clk_en=0, ready=0; REQ: 0/0; WAKE: 1/0; ON: 1/1 (all outputs registered-state decodes, no input-to-output path except test_en_i).
REQ-015 SHALL move OFF->REQ on an edge where demand[i]=1; otherwise stay OFF.
REQ-016 SHALL move REQ->WAKE when granted, REQ->OFF when demand[i]=0 and not granted, else stay REQ.
REQ-017 SHALL, in WAKE, count WAKE_CYCLES cycles (counter cleared on entry) and then enter ON; WAKE lasts exactly WAKE_CYCLES cycles.
REQ-018 SHALL, in ON, keep a per-domain idle counter: cleared on any cycle with busy_i|sw_en_i|wake_req_i, incremented (saturating at IDLE_CYCLES) otherwise.
REQ-019 SHALL move ON->OFF on the edge ending the IDLE_CYCLES-th consecutive idle cycle; clk_en_o falls the following cycle.
REQ-020 SHALL grant at most one domain per cycle, and only when no domain is in WAKE (limits simultaneous wake-up inrush).
REQ-021 SHALL arbitrate REQ domains round-robin: search starts at pointer, pointer becomes granted index+1 (mod NUM_DOMAINS) on each grant; pointer reset value 0.
REQ-022 SHALL, when test_en_i=1, force clk_en_o and ready_o all ones combinationally and freeze all FSMs, counters and the pointer; on test_en_i fall, resume from held state.
REQ-023 SHALL give minimum wake latency: demand high at edge t -> REQ at t+1 -> WAKE (clk_en_o=1) at t+2 -> ON (ready_o=1) at t+2+WAKE_CYCLES.
REQ-024 SHALL treat a demand reasserted in the same cycle ON->OFF would occur as idle-breaking (counter clears, remains ON).

Reset
REQ-025 SHALL, on rst_ni low, asynchronously place all FSMs in OFF, clear all counters and the pointer: clk_en_o=0, ready_o=0, waking_o=0.
REQ-026 SHALL, on reset mid-WAKE or mid-ON, drop clk_en_o immediately; no grant state survives reset.

Structure
REQ-027 SHALL place the state enum (OFF, REQ, WAKE, ON) and counter-width functions in package clk_gate_pkg.
REQ-028 SHALL implement the per-domain FSM and counters as sub-module clk_gate_domain_fsm, instantiated NUM_DOMAINS times, with arbiter and pointer in the top.

Verification (NUM_DOMAINS=4, WAKE_CYCLES=3, IDLE_CYCLES=8)
REQ-029 SHALL check: reset release, sw_en_i=4'b0001 at edge 0 -> clk_en_o[0]=1 from edge 2, ready_o[0]=1 from edge 5, waking_o high edges 2-4.
REQ-030 SHALL check: wake_req_i=4'b1111 together -> WAKE entered in order 0,1,2,3, each 3 cycles, never two domains waking at once.
REQ-031 SHALL check: domain 2 ON, all demand and busy low -> clk_en_o[2] stays 1 for 8 idle cycles, falls on 9th; busy_i[2] pulse at idle count 5 restarts the count.
REQ-032 SHALL check: demand pulse of 1 cycle while another domain is in WAKE -> REQ returns to OFF, no grant, clk_en_o stays 0.
REQ-033 SHALL check: test_en_i=1 with all domains OFF -> clk_en_o=ready_o=4'b1111 same cycle; deassert -> back to 4'b0000, FSMs unchanged.
REQ-034 SHALL check: rst_ni low mid-WAKE of domain 1 -> clk_en_o=0 asynchronously; after release, fresh request gets grant with pointer 0.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: domain state enum and counter/pointer width helpers for the clock-gate sequencer
package clk_gate_pkg;
  typedef enum logic [1:0] {OFF, REQ, WAKE, ON} dom_state_e;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clk_gate_domain_fsm.sv
// clk_gate_domain_fsm: per-domain OFF/REQ/WAKE/ON sequencer; in: clk_i rst_ni hold_i demand_i active_i grant_i, out: req_o waking_o clk_en_o ready_o
module clk_gate_domain_fsm
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hold_i,
  input  logic demand_i,
  input  logic active_i,
  input  logic grant_i,
  output logic req_o,
  output logic waking_o,
  output logic clk_en_o,
  output logic ready_o
);
  localparam int CW = cnt_width(WAKE_CYCLES, IDLE_CYCLES);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);
  dom_state_e state_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q <= '0;
    end else if (!hold_i)
      case (state_q)
        OFF: if (demand_i) state_q <= REQ;
        REQ:
          if (grant_i) begin
            state_q <= WAKE;
            cnt_q <= '0;
          end else if (!demand_i) state_q <= OFF;
        WAKE:
          if (cnt_q == WAKE_LAST) begin
            state_q <= ON;
            cnt_q <= '0;
          end else cnt_q <= cnt_q + CW'(1);
        ON:
          if (active_i) cnt_q <= '0;
          else if (cnt_q == IDLE_LAST) begin
            state_q <= OFF;
            cnt_q <= '0;
          end else if (cnt_q != IDLE_MAX) cnt_q <= cnt_q + CW'(1);
        default: state_q <= OFF;
      endcase
  assign req_o = state_q == REQ;
  assign waking_o = state_q == WAKE;
  assign clk_en_o = state_q == WAKE || state_q == ON;
  assign ready_o = state_q == ON;
endmodule

// File: rtl/clk_gate_sequencer.sv
// clk_gate_sequencer: round-robin one-at-a-time clock-domain wake sequencer with idle auto-gating; in: clk_i rst_ni test_en_i sw_en_i wake_req_i busy_i, out: clk_en_o ready_o waking_o
module clk_gate_sequencer
  import clk_gate_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_en_i,
  input  logic [NUM_DOMAINS-1:0] sw_en_i,
  input  logic [NUM_DOMAINS-1:0] wake_req_i,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] ready_o,
  output logic                   waking_o
);
  localparam int PW = idx_width(NUM_DOMAINS);
  logic [NUM_DOMAINS-1:0] req, wake, en, rdy, grant;
  logic [PW-1:0] ptr_q, ptr_d;
  int idx;
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    idx = 0;
    for (int k = NUM_DOMAINS - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_DOMAINS;
      if (req[idx] && !(|wake) && !test_en_i) begin
        grant = '0;
        grant[idx] = 1'b1;
        ptr_d = PW'((idx + 1) % NUM_DOMAINS);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= '0;
    else ptr_q <= ptr_d;
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    clk_gate_domain_fsm #(
      .WAKE_CYCLES(WAKE_CYCLES),
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_fsm (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .hold_i  (test_en_i),
      .demand_i(sw_en_i[g] | wake_req_i[g]),
      .active_i(sw_en_i[g] | wake_req_i[g] | busy_i[g]),
      .grant_i (grant[g]),
      .req_o   (req[g]),
      .waking_o(wake[g]),
      .clk_en_o(en[g]),
      .ready_o (rdy[g])
    );
  end
  assign clk_en_o = test_en_i ? '1 : en;
  assign ready_o = test_en_i ? '1 : rdy;
  assign waking_o = |wake;
endmodule

// File: tb/tb_clk_gate_sequencer.sv
// tb_clk_gate_sequencer: table, directed and random checks of clk_gate_sequencer against a behavioural model
module tb_clk_gate_sequencer;
  localparam int N = 4;
  localparam int W = 3;
  localparam int I = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic test_en;
  logic [N-1:0] sw_en, wake_req, busy, clk_en, ready;
  logic waking;
  int n_chk = 0;
  int n_fail = 0;
  int mode[N];
  int tmr[N];
  int mptr;
  typedef struct {
    logic [N-1:0] sw;
    logic [N-1:0] en;
    logic [N-1:0] rdy;
    logic wak;
  } vec_t;
  vec_t tv[8];
  clk_gate_sequencer #(.NUM_DOMAINS(N), .WAKE_CYCLES(W), .IDLE_CYCLES(I)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .test_en_i (test_en),
    .sw_en_i   (sw_en),
    .wake_req_i(wake_req),
    .busy_i    (busy),
    .clk_en_o  (clk_en),
    .ready_o   (ready),
    .waking_o  (waking)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mode[i] = 0;
      tmr[i] = 0;
    end
    mptr = 0;
  endtask
  // Modes: 0 off, 1 requesting, 2 waking (tmr = cycles left), 3 on (tmr = idle run length)
  task automatic model_edge();
    int g;
    bit any_wake;
    bit dem;
    g = -1;
    any_wake = 0;
    if (test_en) return;
    for (int i = 0; i < N; i++) if (mode[i] == 2) any_wake = 1;
    for (int k = 0; k < N; k++)
      if (!any_wake && g < 0 && mode[(mptr + k) % N] == 1) g = (mptr + k) % N;
    if (g >= 0) mptr = (g + 1) % N;
    for (int i = 0; i < N; i++) begin
      dem = sw_en[i] | wake_req[i];
      case (mode[i])
        0: if (dem) mode[i] = 1;
        1: if (i == g) begin mode[i] = 2; tmr[i] = W; end else if (!dem) mode[i] = 0;
        2: begin tmr[i]--; if (tmr[i] == 0) mode[i] = 3; end
        default:
          if (busy[i] || dem) tmr[i] = 0;
          else begin
            tmr[i]++;
            if (tmr[i] == I) begin mode[i] = 0; tmr[i] = 0; end
          end
      endcase
    end
  endtask
  function automatic logic [N-1:0] m_en();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = test_en || mode[i] >= 2;
    return r;
  endfunction
  function automatic logic [N-1:0] m_rdy();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = test_en || mode[i] == 3;
    return r;
  endfunction
  function automatic logic m_wak();
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++) r |= mode[i] == 2;
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model clk_en", clk_en, m_en());
    chk("model ready", ready, m_rdy());
    chk("model waking", waking, m_wak());
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    test_en = 1'b0;
    sw_en = '0;
    wake_req = '0;
    busy = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset clk_en", clk_en, 0);
    chk("reset ready", ready, 0);
    chk("reset waking", waking, 0);
    rst_n = 1'b1;
  endtask
  initial begin
    int hi;
    logic [N-1:0] act, exp;
    tv[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tv[1] = '{4'b0001, 4'b0000, 4'b0000, 1'b0};
    for (int r = 2; r < 5; r++) tv[r] = '{4'b0001, 4'b0001, 4'b0000, 1'b1};
    for (int r = 5; r < 8; r++) tv[r] = '{4'b0001, 4'b0001, 4'b0001, 1'b0};
    do_reset();
    for (int r = 0; r < 8; r++) begin
      sw_en = tv[r].sw;
      step();
      chk($sformatf("tbl%0d clk_en", r), clk_en, tv[r].en);
      chk($sformatf("tbl%0d ready", r), ready, tv[r].rdy);
      chk($sformatf("tbl%0d waking", r), waking, tv[r].wak);
    end
    do_reset();
    wake_req = 4'b1111;
    for (int e = 1; e <= 18; e++) begin
      step();
      act = clk_en & ~ready;
      exp = (e >= 2 && (e - 2) % 4 < 3 && (e - 2) / 4 < N) ? N'(1 << ((e - 2) / 4)) : '0;
      chk($sformatf("wake order e%0d", e), act, exp);
      chk("single waker", $countones(act) <= 1, 1);
    end
    do_reset();
    wake_req = 4'b0100;
    repeat (5) step();
    chk("d2 ready", ready[2], 1);
    wake_req = '0;
    hi = 0;
    for (int e = 1; e <= 30 && clk_en[2]; e++) begin
      step();
      if (clk_en[2]) hi++;
    end
    chk("idle hold cycles", hi, I - 1);
    chk("idle gated", clk_en[2], 0);
    wake_req = 4'b0100;
    for (int k = 0; k < 20 && !ready[2]; k++) step();
    chk("d2 ready again", ready[2], 1);
    wake_req = '0;
    hi = 0;
    for (int e = 1; e <= 40 && clk_en[2]; e++) begin
      busy = (e == 6) ? 4'b0100 : 4'b0000;
      step();
      if (clk_en[2]) hi++;
    end
    busy = '0;
    chk("busy restart hold", hi, 5 + I);
    do_reset();
    sw_en = 4'b0001;
    repeat (2) step();
    wake_req = 4'b1000;
    step();
    wake_req = '0;
    step();
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (clk_en[3]) hi++;
    end
    chk("pulse no grant", hi, 0);
    do_reset();
    test_en = 1'b1;
    #1;
    chk("test clk_en", clk_en, 4'b1111);
    chk("test ready", ready, 4'b1111);
    sw_en = 4'b1111;
    repeat (3) step();
    test_en = 1'b0;
    sw_en = '0;
    #1;
    chk("test off clk_en", clk_en, 0);
    chk("test off ready", ready, 0);
    step();
    chk("frozen clk_en", clk_en, 0);
    do_reset();
    sw_en = 4'b0011;
    repeat (7) step();
    chk("mid wake d1 en", clk_en, 4'b0011);
    chk("mid wake waking", waking, 1);
    #2 rst_n = 1'b0;
    sw_en = '0;
    #1;
    chk("async rst clk_en", clk_en, 0);
    chk("async rst waking", waking, 0);
    model_reset();
    @(negedge clk);
    wake_req = 4'b1010;
    rst_n = 1'b1;
    repeat (2) step();
    chk("post rst grant ptr0", clk_en, 4'b0010);
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) sw_en = N'($urandom & $urandom);
      if ($urandom_range(0, 3) == 0) wake_req = N'($urandom & $urandom & $urandom);
      busy = N'($urandom & $urandom);
      test_en = $urandom_range(0, 24) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
